// File: rtl/level_banner_ctrl.sv
// Level banner controller: converts the camera level to two BCD digits with a
// sequential double-dabble and holds an on-screen banner for HOLD_FRAMES frames.
module level_banner_ctrl #(
    parameter int unsigned LEVEL_WIDTH = 5,
    parameter int unsigned HOLD_FRAMES = 120
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEVEL_WIDTH-1:0] level_in,
    input  logic                   frame_tick,
    output logic [3:0]             tens,
    output logic [3:0]             ones,
    output logic                   digits_valid,
    output logic                   banner_on,
    output logic                   busy
);

    localparam int unsigned BCD_W   = 8;
    localparam int unsigned SR_W    = LEVEL_WIDTH + BCD_W;
    localparam int unsigned ITER_W  = 3;
    localparam int unsigned HOLD_W  = 8;
    localparam int unsigned ONES_LO = LEVEL_WIDTH;
    localparam int unsigned TENS_LO = LEVEL_WIDTH + 4;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(LEVEL_WIDTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LEVEL_WIDTH-1:0] last_level_q, last_level_d;
    logic [SR_W-1:0]        sr_q, sr_d;
    logic [ITER_W-1:0]      iter_q, iter_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [3:0]             tens_q, tens_d;
    logic [3:0]             ones_q, ones_d;
    logic                   valid_q, valid_d;
    logic                   banner_q, banner_d;
    logic                   busy_q, busy_d;

    logic [SR_W-1:0]        sr_adj;
    logic [SR_W-1:0]        sr_step;
    logic                   level_change;

    // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift left.
    always_comb begin
        sr_adj = sr_q;
        if (sr_q[ONES_LO +: 4] >= 4'd5) begin
            sr_adj[ONES_LO +: 4] = sr_q[ONES_LO +: 4] + 4'd3;
        end
        if (sr_q[TENS_LO +: 4] >= 4'd5) begin
            sr_adj[TENS_LO +: 4] = sr_q[TENS_LO +: 4] + 4'd3;
        end
        sr_step = sr_adj << 1;
    end

    assign level_change = (level_in != last_level_q);

    // Next-state and next-output logic; a level change outranks the final hold tick.
    always_comb begin
        state_d      = state_q;
        last_level_d = last_level_q;
        sr_d         = sr_q;
        iter_d       = iter_q;
        hold_cnt_d   = hold_cnt_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        valid_d      = valid_q;
        banner_d     = banner_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE, SHOW: begin
                if (level_change) begin
                    last_level_d = level_in;
                    sr_d         = {BCD_W'(0), level_in};
                    iter_d       = '0;
                    busy_d       = 1'b1;
                    state_d      = CONVERT;
                end else if ((state_q == SHOW) && frame_tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        banner_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            CONVERT: begin
                sr_d   = sr_step;
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_LAST) begin
                    tens_d     = sr_step[TENS_LO +: 4];
                    ones_d     = sr_step[ONES_LO +: 4];
                    valid_d    = 1'b1;
                    banner_d   = 1'b1;
                    hold_cnt_d = '0;
                    busy_d     = 1'b0;
                    state_d    = SHOW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_level_q <= '0;
            sr_q         <= '0;
            iter_q       <= '0;
            hold_cnt_q   <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            valid_q      <= 1'b0;
            banner_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_level_q <= last_level_d;
            sr_q         <= sr_d;
            iter_q       <= iter_d;
            hold_cnt_q   <= hold_cnt_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            valid_q      <= valid_d;
            banner_q     <= banner_d;
            busy_q       <= busy_d;
        end
    end

    assign tens         = tens_q;
    assign ones         = ones_q;
    assign digits_valid = valid_q;
    assign banner_on    = banner_q;
    assign busy         = busy_q;

endmodule

// File: doc/level_banner_ctrl.md
LEVEL_BANNER_CTRL -- requirements
Module: level_banner_ctrl

Interface
REQ-001 The block SHALL have parameter LEVEL_WIDTH, default 5, giving the width of the level input; the legal range SHALL be 1..6 (maximum value 63 fits two BCD digits).
REQ-002 The block SHALL have parameter HOLD_FRAMES, default 120, giving the number of frame ticks for which the banner stays on; the legal range SHALL be 1..255.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 The block SHALL have port level_in  input  LEVEL_WIDTH  current camera level, binary.
REQ-006 The block SHALL have port frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 The block SHALL have port tens  output  4  registered BCD tens digit of the last converted level.
REQ-008 The block SHALL have port ones  output  4  registered BCD ones digit of the last converted level.
REQ-009 The block SHALL have port digits_valid  output  1  high once at least one conversion has completed since reset.
REQ-010 The block SHALL have port banner_on  output  1  high while the level banner is to be drawn.
REQ-011 The block SHALL have port busy  output  1  high while in CONVERT.

Function
REQ-012 The FSM SHALL have three states: IDLE, CONVERT and SHOW.
REQ-013 The block SHALL hold a register last_level.
REQ-014 On a clock edge in IDLE or SHOW with level_in != last_level, the block SHALL:
  - capture level_in into the conversion shift register and into last_level;
  - clear the BCD accumulator and set iteration count = 0;
  - enter CONVERT.
REQ-015 CONVERT SHALL perform sequential double-dabble, one iteration per cycle: each BCD nibble >= 5 gets +3, then the whole register shifts left by 1.
REQ-016 CONVERT SHALL last exactly LEVEL_WIDTH cycles.
REQ-017 On the final CONVERT edge (LEVEL_WIDTH edges after the capture edge), the block SHALL:
  - load the result into tens and ones;
  - set digits_valid = 1 and banner_on = 1;
  - clear hold_cnt;
  - enter SHOW.
REQ-018 tens and ones SHALL change only on the final CONVERT edge; while busy they SHALL keep their previous values (no partial results visible).
REQ-019 level_in changes during CONVERT SHALL be ignored; after entering SHOW, the comparison in REQ-014 SHALL re-detect any mismatch and restart conversion.
REQ-020 In SHOW, each frame_tick SHALL increment hold_cnt.
REQ-021 A frame_tick in SHOW with hold_cnt == HOLD_FRAMES-1 SHALL clear banner_on and return the FSM to IDLE.
REQ-022 frame_tick SHALL be ignored in IDLE and in CONVERT.
REQ-023 If a level change and the final frame_tick occur on the same edge in SHOW, the level change SHALL win: the FSM enters CONVERT and banner_on stays 1.
REQ-024 A level change in SHOW SHALL keep banner_on = 1 through the new conversion; hold_cnt SHALL restart from 0 at the end of that conversion.
REQ-025 busy SHALL be 1 exactly in CONVERT.
REQ-026 banner_on SHALL be 1 in SHOW, and in CONVERT when CONVERT was entered from SHOW; it SHALL be 0 otherwise.
REQ-027 hold_cnt SHALL be 8 bits wide and SHALL never wrap, because the FSM leaves SHOW at HOLD_FRAMES-1.
REQ-028 Level 0 SHALL be converted only when last_level differs from it.

Reset
REQ-029 While rst = 1, asynchronously:
  - state = IDLE, last_level = 0, hold_cnt = 0, iteration count = 0;
  - tens = 0, ones = 0, digits_valid = 0, banner_on = 0, busy = 0.
REQ-030 Reset asserted mid-CONVERT or mid-SHOW SHALL abort immediately with no output update.
REQ-031 After reset releases, the first edge with level_in != 0 SHALL start a conversion.

Verification (LEVEL_WIDTH = 5, HOLD_FRAMES = 3)
REQ-032 Conversion: reset, then level_in = 23 -> busy high for 5 cycles; tens = 2, ones = 3, digits_valid = 1 and banner_on = 1 exactly 5 edges after the capture edge.
REQ-033 Maximum value: level_in = 31 -> tens = 3, ones = 1; level_in = 9 -> tens = 0, ones = 9; outputs unchanged during busy.
REQ-034 Hold timing: after conversion, 3 frame_tick pulses -> banner_on falls on the edge of the 3rd tick; ticks during CONVERT do not count.
REQ-035 Change in SHOW: level 12 shown, after 1 tick level_in = 13 -> banner_on stays 1, busy for 5 cycles, ones = 3, then 3 fresh ticks are required before banner_on falls.
REQ-036 Change mid-CONVERT: level_in 5 -> 7 on the 2nd CONVERT cycle -> result 5 is loaded first, then an automatic reconversion produces 7.
REQ-037 Reset mid-CONVERT: assert rst on the 3rd CONVERT cycle -> all outputs 0 at once; after release with level_in = 4, a new conversion produces ones = 4.
